// File: rtl/axi_slave_wr_chk.sv
// AXI write-channel slave that checks W beats against its queued AW bursts and
// answers each burst on B. Define AXI_SLV_WR_DATA_CHK_EN to enable the W data-pattern compare.
module axi_slave_wr_chk #(
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int AQ_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic                    chk_clear,
  input  logic [31:0]             exp_init_data,
  output logic [31:0]             burst_cnt,
  output logic [39:0]             beat_cnt,
  output logic                    data_error,
  output logic [ADDR_WIDTH-1:0]   err_addr
);

  localparam int PTR_W = $clog2(AQ_DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(AQ_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
  } aq_entry_t;

  aq_entry_t        aq_mem [AQ_DEPTH];
  logic [PTR_W-1:0] wr_idx, rd_idx;
  logic [PTR_W:0]   aq_count;
  aq_entry_t        head;

  logic [7:0] beat_idx;
  logic       burst_bad;
  logic       aw_hs, w_hs, b_hs, last_beat, w_last_hs;
  logic       proto_err, data_mismatch, beat_err;

  assign head          = aq_mem[rd_idx];
  assign s_axi_awready = (aq_count != DEPTH_L);
  // A pending, unaccepted B response blocks all W traffic so no response is overwritten.
  assign s_axi_wready  = (aq_count != '0) && !(s_axi_bvalid && !s_axi_bready);

  assign aw_hs     = s_axi_awvalid && s_axi_awready;
  assign w_hs      = s_axi_wvalid && s_axi_wready;
  assign b_hs      = s_axi_bvalid && s_axi_bready;
  assign last_beat = (beat_idx == head.len);
  assign w_last_hs = w_hs && last_beat;
  assign proto_err = (s_axi_wlast != last_beat);
  assign beat_err  = proto_err || data_mismatch;

  // NOTE: queue storage has no reset; emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (aw_hs) aq_mem[wr_idx] <= '{id: s_axi_awid, addr: s_axi_awaddr, len: s_axi_awlen};
  end

  // NOTE: all state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      aq_count <= '0;
    end else begin
      if (aw_hs)     wr_idx <= wr_idx + 1'b1;
      if (w_last_hs) rd_idx <= rd_idx + 1'b1;
      case ({aw_hs, w_last_hs})
        2'b10:   aq_count <= aq_count + 1'b1;
        2'b01:   aq_count <= aq_count - 1'b1;
        default: aq_count <= aq_count;
      endcase
    end
  end

  // Burst position and accumulated error; the last beat ends the burst whatever wlast says.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx  <= '0;
      burst_bad <= 1'b0;
    end else if (w_hs) begin
      if (last_beat) begin
        beat_idx  <= '0;
        burst_bad <= 1'b0;
      end else begin
        beat_idx  <= beat_idx + 1'b1;
        burst_bad <= burst_bad || beat_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_bvalid <= 1'b0;
      s_axi_bid    <= '0;
      s_axi_bresp  <= RESP_OKAY;
    end else if (w_last_hs) begin
      s_axi_bvalid <= 1'b1;
      s_axi_bid    <= head.id;
      s_axi_bresp  <= (burst_bad || beat_err) ? RESP_SLVERR : RESP_OKAY;
    end else if (b_hs) begin
      s_axi_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      burst_cnt <= '0;
    end else if (chk_clear) begin
      beat_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      if (w_hs) beat_cnt  <= beat_cnt + 1'b1;
      if (b_hs) burst_cnt <= burst_cnt + 1'b1;
    end
  end

`ifdef AXI_SLV_WR_DATA_CHK_EN
  logic [31:0] exp_lane;

  // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latch).
  always_comb begin
    exp_lane      = exp_init_data + beat_cnt[31:0];
    data_mismatch = 1'b0;
    for (int l = 0; l < DATA_WIDTH/32; l++) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi_wstrb[4*l+b] && (s_axi_wdata[32*l+8*b +: 8] != exp_lane[8*b +: 8]))
          data_mismatch = 1'b1;
      end
    end
  end

  // Only the first failing burst's address is kept until the next clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_error <= 1'b0;
      err_addr   <= '0;
    end else if (chk_clear) begin
      data_error <= 1'b0;
      err_addr   <= '0;
    end else if (w_hs && data_mismatch) begin
      data_error <= 1'b1;
      if (!data_error) err_addr <= head.addr;
    end
  end
`else
  logic unused_data_ok;

  assign data_mismatch  = 1'b0;
  assign data_error     = 1'b0;
  assign err_addr       = '0;
  assign unused_data_ok = ^{s_axi_wdata, s_axi_wstrb, exp_init_data, head.addr};
`endif

endmodule
